i2s_receiver: RTL and testbench
===============================

Name: i2s_receiver

Overview:
- Deserialises a standard I2S stream (MSB one bit-clock after each word_select transition, 2 channels per frame) into parallel left/right samples.
- Sits at the codec ADC / line-in side of the audio path, and is the counterpart of the 32-bit-frame, 16-bit-per-channel transmitter.
- The codec drives the bit clock. Samples are emitted once per frame with a one-cycle strobe for the downstream processing chain.

Parameters:
- DATA_WIDTH, 16, bits per output sample. Bits received beyond this are discarded; missing LSBs are zero-filled.

Ports:
- serial_clk  in  1  bit clock (3.072 MHz nominal). Every register in the block is clocked on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- word_select  in  1  I2S WS: 0 = left channel, 1 = right channel.
- sound_bit_in  in  1  I2S serial data, MSB first.
- left_data  out  DATA_WIDTH  last complete left sample.
- right_data  out  DATA_WIDTH  last complete right sample.
- sample_valid  out  1  one-cycle strobe: left_data/right_data hold a new frame pair.
- locked  out  1  high once the first left-word start has been found.
- word_len_err  out  1  sticky word-length error flag (see Optional Feature).

Behaviour:
- Reset (async, active-low): left_data=0, right_data=0, sample_valid=0, locked=0, word_len_err=0, ws_prev=0, bit_cnt=0, assembly register=0, state=IDLE.
- word_select and sound_bit_in are sampled on every rising serial_clk edge. The external driver changes them on the falling edge. When the block is fed by a rising-edge driver (loopback), both inputs are seen one cycle late; relative alignment is preserved and behaviour is identical.
- Edge detect: ws_edge = (word_select != ws_prev). ws_prev is updated every cycle.
- On the ws_edge cycle, the sampled sound_bit_in is the LSB of the word just ending, per I2S. The MSB of the new word arrives on the following cycle.
- bit_cnt counts bits of the current word, starting at 0 on the cycle after ws_edge, and saturates at 31.
- Bit placement: on a non-edge cycle with bit_cnt < DATA_WIDTH, write assembly[DATA_WIDTH-1-bit_cnt] = sound_bit_in. Bits with bit_cnt >= DATA_WIDTH are dropped.
- Completed word on the edge cycle: the assembly register plus the edge-cycle bit placed at index DATA_WIDTH-1-bit_cnt, but only if bit_cnt < DATA_WIDTH.
- After the edge cycle, clear the assembly register to 0 and set bit_cnt=0.
- States:
  - IDLE: the receiver collects nothing useful. A 0->1 edge is ignored. A 1->0 edge goes to RX_LEFT and sets locked=1. The word ending on that edge is discarded.
  - RX_LEFT: a 0->1 edge latches the completed word into an internal left_hold and goes to RX_RIGHT. left_data is not updated yet.
  - RX_RIGHT: a 1->0 edge drives left_data<=left_hold, right_data<=completed word and sample_valid<=1 for exactly one cycle, then goes to RX_LEFT.
- Latency: sample_valid and the new data are visible on the cycle after the 1->0 edge is sampled. Both outputs hold until the next frame.
- With DATA_WIDTH=16 and a 32-bit frame, a 1->0 edge occurs every 32 cycles, giving one sample_valid per 32 cycles.
- No WS edge: bit_cnt saturates at 31, no output is produced, and state holds.
- Reset mid-word returns the block to IDLE. The partial word is lost, and the next output requires a full left+right frame after the next 1->0 edge.

Optional Feature:
- Macro: I2S_RX_WORD_CHECK_EN.
- Defined: on every ws_edge in RX_LEFT or RX_RIGHT, received length = bit_cnt+1. If it is not equal to DATA_WIDTH, set word_len_err=1. The flag stays set until reset. Data is still output, truncated or zero-filled.
- Undefined: word_len_err is tied to 0 and no length check logic is built.

Test Plan:
- Reset, then 2 frames: L=16'hA5C3, R=16'h1234 (MSB 1 cycle after WS edge) -> locked=1 after first 1->0; sample_valid 1 cycle after second frame's 1->0 edge; left_data=A5C3, right_data=1234; strobes spaced by 32 cycles.
- Continuous frames: L=8000, R=7FFF, then L=0001, R=FFFF -> outputs update per frame; sample_valid exactly 1 cycle wide; no strobe between frames.
- Start stream mid-right-word after reset -> no sample_valid until a full left+right word pair completes after the first 1->0 edge.
- 24-bit words (48-cycle frame), L=24'hABCDEF -> left_data=ABCD; with I2S_RX_WORD_CHECK_EN, word_len_err=1.
- 12-bit words, L=12'hFFF -> left_data=FFF0; with the macro defined, word_len_err=1; without it, word_len_err stays 0.
- Assert reset mid-left-word, release -> all outputs 0 and locked=0 immediately; the next valid frame decodes correctly.

Source files
------------

// File: rtl/i2s_receiver_if.sv
// Signal bundle between an I2S source (codec side) and the i2s_receiver.
// The receiver connects through the slave modport; the stream source and sample consumer use master.
interface i2s_receiver_if #(
  parameter int DATA_WIDTH = 16
) ();
  logic                  word_select;
  logic                  sound_bit_in;
  logic [DATA_WIDTH-1:0] left_data;
  logic [DATA_WIDTH-1:0] right_data;
  logic                  sample_valid;
  logic                  locked;
  logic                  word_len_err;

  modport master (
    output word_select,
    output sound_bit_in,
    input  left_data,
    input  right_data,
    input  sample_valid,
    input  locked,
    input  word_len_err
  );

  modport slave (
    input  word_select,
    input  sound_bit_in,
    output left_data,
    output right_data,
    output sample_valid,
    output locked,
    output word_len_err
  );
endinterface

// File: rtl/i2s_receiver.sv
// I2S deserialiser: one left/right sample pair per frame with a one-cycle sample_valid strobe.
// Optional word-length checking is built when I2S_RX_WORD_CHECK_EN is defined.
//
// state    | meaning
// IDLE     | searching for the first 1->0 word_select edge (start of a left word)
// RX_LEFT  | assembling a left word; 0->1 edge stores it in the left hold register
// RX_RIGHT | assembling a right word; 1->0 edge publishes the frame pair
module i2s_receiver #(
  parameter int DATA_WIDTH = 16
) (
  input logic          serial_clk,
  input logic          reset,
  i2s_receiver_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RX_LEFT  = 2'd1,
    RX_RIGHT = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ws_prev;
  logic [4:0]            r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_assembly;
  logic [DATA_WIDTH-1:0] r_left_hold;
  logic [DATA_WIDTH-1:0] r_left_data;
  logic [DATA_WIDTH-1:0] r_right_data;
  logic                  r_sample_valid;
  logic                  r_locked;

  logic                  w_ws_edge;
  logic [DATA_WIDTH-1:0] w_placed;
  logic                  w_lock;
  logic                  w_latch_left;
  logic                  w_emit;

  assign w_ws_edge = (bus.word_select != r_ws_prev);

  // Assembly with the current bit dropped into its slot; bits past DATA_WIDTH match no slot.
  // On an edge cycle this is the completed word, otherwise the next assembly value.
  always_comb begin
    w_placed = r_assembly;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if ({27'd0, r_bit_cnt} == 32'(DATA_WIDTH - 1 - i)) begin
        w_placed[i] = bus.sound_bit_in;
      end
    end
  end

  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_lock       = 1'b0;
    w_latch_left = 1'b0;
    w_emit       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ws_edge && !bus.word_select) begin
          w_state_nxt = RX_LEFT;
          w_lock      = 1'b1;
        end
      end
      RX_LEFT: begin
        if (w_ws_edge && bus.word_select) begin
          w_state_nxt  = RX_RIGHT;
          w_latch_left = 1'b1;
        end
      end
      RX_RIGHT: begin
        if (w_ws_edge && !bus.word_select) begin
          w_state_nxt = RX_LEFT;
          w_emit      = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      r_ws_prev      <= 1'b0;
      r_bit_cnt      <= 5'd0;
      r_assembly     <= '0;
      r_left_hold    <= '0;
      r_left_data    <= '0;
      r_right_data   <= '0;
      r_sample_valid <= 1'b0;
      r_locked       <= 1'b0;
    end else begin
      r_ws_prev      <= bus.word_select;
      r_sample_valid <= w_emit;
      if (w_ws_edge) begin
        r_assembly <= '0;
        r_bit_cnt  <= 5'd0;
      end else begin
        r_assembly <= w_placed;
        if (r_bit_cnt != 5'd31) begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
        end
      end
      if (w_lock) begin
        r_locked <= 1'b1;
      end
      if (w_latch_left) begin
        r_left_hold <= w_placed;
      end
      if (w_emit) begin
        r_left_data  <= r_left_hold;
        r_right_data <= w_placed;
      end
    end
  end

`ifdef I2S_RX_WORD_CHECK_EN
  logic       r_word_len_err;
  logic [5:0] w_rx_len;

  assign w_rx_len = {1'b0, r_bit_cnt} + 6'd1;

  // The edge cycle carries the LSB, so the word length is bit_cnt + 1.
  always_ff @(posedge serial_clk or negedge reset) begin
    if (!reset) begin
      r_word_len_err <= 1'b0;
    end else if (w_ws_edge && (r_state == RX_LEFT || r_state == RX_RIGHT) &&
                 (32'(w_rx_len) != 32'(DATA_WIDTH))) begin
      r_word_len_err <= 1'b1;
    end
  end

  assign bus.word_len_err = r_word_len_err;
`else
  assign bus.word_len_err = 1'b0;
`endif

  assign bus.left_data    = r_left_data;
  assign bus.right_data   = r_right_data;
  assign bus.sample_valid = r_sample_valid;
  assign bus.locked       = r_locked;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: frame decode, lock, strobe timing, odd word lengths and reset.
// Expected word_len_err follows I2S_RX_WORD_CHECK_EN.
module tb_i2s_receiver;
  localparam int DW = 16;

`ifdef I2S_RX_WORD_CHECK_EN
  localparam logic [31:0] EXP_LEN_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_LEN_ERR = 32'd0;
`endif

  logic serial_clk = 1'b0;
  logic reset      = 1'b0;
  int   n_cmp      = 0;
  int   n_err      = 0;

  i2s_receiver_if #(.DATA_WIDTH(DW)) bus ();

  i2s_receiver #(.DATA_WIDTH(DW)) dut (
    .serial_clk (serial_clk),
    .reset      (reset),
    .bus        (bus)
  );

  always #10 serial_clk = ~serial_clk;

  // Strobe monitor, sampled on the falling edge.
  int          cyc        = 0;
  int          n_strobe   = 0;
  int          strobe_cyc = 0;
  int          strobe_gap = 0;
  int          n_wide     = 0;
  logic        prev_valid = 1'b0;
  logic [DW-1:0] cap_l    = '0;
  logic [DW-1:0] cap_r    = '0;
  logic        g_last_lsb = 1'b0;

  always @(negedge serial_clk) begin
    cyc = cyc + 1;
    if (bus.sample_valid) begin
      if (prev_valid) n_wide = n_wide + 1;
      n_strobe   = n_strobe + 1;
      strobe_gap = cyc - strobe_cyc;
      strobe_cyc = cyc;
      cap_l      = bus.left_data;
      cap_r      = bus.right_data;
    end
    prev_valid = bus.sample_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One I2S word slot: the first cycle of the slot carries the previous word's LSB.
  task automatic send_word(input logic ch, input logic [31:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge serial_clk);
      bus.word_select  = ch;
      bus.sound_bit_in = (i == 0) ? g_last_lsb : word[5'(n - i)];
    end
    g_last_lsb = word[0];
    @(posedge serial_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge serial_clk);
    reset            = 1'b0;
    bus.word_select  = 1'b0;
    bus.sound_bit_in = 1'b0;
    g_last_lsb       = 1'b0;
    repeat (2) @(negedge serial_clk);
    reset = 1'b1;
  endtask

  int s0;

  initial begin
    bus.word_select  = 1'b0;
    bus.sound_bit_in = 1'b0;
    repeat (3) @(negedge serial_clk);
    #1;
    chk("rst_left",   32'(bus.left_data),    32'h0);
    chk("rst_right",  32'(bus.right_data),   32'h0);
    chk("rst_valid",  32'(bus.sample_valid), 32'h0);
    chk("rst_locked", 32'(bus.locked),       32'h0);
    chk("rst_lenerr", 32'(bus.word_len_err), 32'h0);
    @(negedge serial_clk);
    reset = 1'b1;

    // Basic frame and lock
    send_word(1'b1, 32'h0F0F, 16);
    chk("prelock", 32'(bus.locked), 32'h0);
    send_word(1'b0, 32'hA5C3, 16);
    chk("lock", 32'(bus.locked), 32'h1);
    s0 = n_strobe;
    send_word(1'b1, 32'h1234, 16);
    chk("no_strobe_mid_frame", n_strobe, s0);
    send_word(1'b0, 32'h8000, 16);
    chk("f1_count", n_strobe, s0 + 1);
    chk("f1_left",  32'(cap_l), 32'hA5C3);
    chk("f1_right", 32'(cap_r), 32'h1234);
    chk("f1_hold",  32'(bus.left_data), 32'hA5C3);

    // Continuous frames
    send_word(1'b1, 32'h7FFF, 16);
    send_word(1'b0, 32'h0001, 16);
    chk("f2_count", n_strobe, s0 + 2);
    chk("f2_gap",   strobe_gap, 32);
    chk("f2_left",  32'(cap_l), 32'h8000);
    chk("f2_right", 32'(cap_r), 32'h7FFF);
    send_word(1'b1, 32'hFFFF, 16);
    send_word(1'b0, 32'h0000, 16);
    chk("f3_count", n_strobe, s0 + 3);
    chk("f3_gap",   strobe_gap, 32);
    chk("f3_left",  32'(cap_l), 32'h0001);
    chk("f3_right", 32'(cap_r), 32'hFFFF);
    chk("strobe_width", n_wide, 0);
    chk("lenerr_16", 32'(bus.word_len_err), 32'h0);

    // Reset mid-left-word
    send_word(1'b1, 32'h1111, 16);
    send_word(1'b0, 32'h5A5A, 9);
    chk("f4_left",  32'(cap_l), 32'h0000);
    chk("f4_right", 32'(cap_r), 32'h1111);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_left",   32'(bus.left_data),    32'h0);
    chk("arst_right",  32'(bus.right_data),   32'h0);
    chk("arst_valid",  32'(bus.sample_valid), 32'h0);
    chk("arst_locked", 32'(bus.locked),       32'h0);
    bus.word_select = 1'b0;
    g_last_lsb      = 1'b0;
    repeat (2) @(negedge serial_clk);
    reset = 1'b1;
    s0 = n_strobe;
    send_word(1'b1, 32'h0000, 16);
    send_word(1'b0, 32'hC0DE, 16);
    send_word(1'b1, 32'hBEEF, 16);
    send_word(1'b0, 32'h0000, 16);
    chk("f5_count", n_strobe, s0 + 1);
    chk("f5_left",  32'(cap_l), 32'hC0DE);
    chk("f5_right", 32'(cap_r), 32'hBEEF);

    // Stream starting mid-right-word after reset
    do_reset();
    s0 = n_strobe;
    send_word(1'b1, 32'h0055, 7);
    send_word(1'b0, 32'h1357, 16);
    send_word(1'b1, 32'h2468, 16);
    chk("mid_no_strobe", n_strobe, s0);
    send_word(1'b0, 32'h0000, 16);
    chk("mid_count", n_strobe, s0 + 1);
    chk("mid_left",  32'(cap_l), 32'h1357);
    chk("mid_right", 32'(cap_r), 32'h2468);

    // 24-bit words: extra LSBs dropped
    do_reset();
    s0 = n_strobe;
    send_word(1'b1, 32'h000000, 24);
    send_word(1'b0, 32'hABCDEF, 24);
    send_word(1'b1, 32'h654321, 24);
    send_word(1'b0, 32'h000000, 24);
    chk("w24_count", n_strobe, s0 + 1);
    chk("w24_left",  32'(cap_l), 32'hABCD);
    chk("w24_right", 32'(cap_r), 32'h6543);
    chk("w24_lenerr", 32'(bus.word_len_err), EXP_LEN_ERR);

    // 12-bit words: missing LSBs zero-filled
    do_reset();
    #1;
    chk("w12_rst_lenerr", 32'(bus.word_len_err), 32'h0);
    s0 = n_strobe;
    send_word(1'b1, 32'h000, 12);
    send_word(1'b0, 32'hFFF, 12);
    send_word(1'b1, 32'hABC, 12);
    send_word(1'b0, 32'h000, 12);
    chk("w12_count", n_strobe, s0 + 1);
    chk("w12_left",  32'(cap_l), 32'hFFF0);
    chk("w12_right", 32'(cap_r), 32'hABC0);
    chk("w12_lenerr", 32'(bus.word_len_err), EXP_LEN_ERR);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
